// File: rtl/mp_responder.sv
`default_nettype none
// ============================================================================
// Module   : mp_responder
// Purpose  : Main-memory responder for cache fills (reads) and dirty-line
//            write-backs (writes). 256 x 8 register array behind a
//            valid/ready request channel with a fixed access latency and a
//            one-cycle completion pulse for both reads and writes.
// Ports    : clock        - rising-edge clock
//            reset        - synchronous, active-high
//            req_valid    - request present
//            req_ready    - responder idle, can accept a request
//            req_wren     - 1 = write, 0 = read
//            req_address  - 8-bit word address
//            req_data     - write data (ignored for reads)
//            resp_valid   - one-cycle completion pulse
//            resp_wren    - echo of the accepted req_wren
//            resp_data    - read data, or the written data for a write
//            rd_count     - completed reads, modulo 256
//            wr_count     - completed writes, modulo 256
// Revision : 1.0 - initial release
// ============================================================================
module mp_responder #(
  parameter int LATENCY      = 2,
  parameter int INIT_PATTERN = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wren,
  input  logic [7:0] req_address,
  input  logic [7:0] req_data,
  output logic       resp_valid,
  output logic       resp_wren,
  output logic [7:0] resp_data,
  output logic [7:0] rd_count,
  output logic [7:0] wr_count
);

  // Reject builds whose latency does not fit the 4-bit down-counter.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mp_responder: LATENCY must be in 1..15");
  end

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  localparam logic [3:0] c_lat_load = 4'(LATENCY - 1);

  // Power-up image of the array: identity pattern or all zero.
  function automatic logic [255:0][7:0] f_mem_init();
    logic [255:0][7:0] v;
    for (int i = 0; i < 256; i++) begin
      v[i] = (INIT_PATTERN != 0) ? 8'(i) : 8'h00;
    end
    return v;
  endfunction

  localparam logic [255:0][7:0] c_mem_init = f_mem_init();

  // The array carries no reset; its contents survive reset and only the
  // declaration initialiser defines the power-up image.
  logic [255:0][7:0] r_mem = c_mem_init;

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic       r_wren;
  logic       r_resp_wren;
  logic [7:0] r_resp_data;
  logic [7:0] r_rd_count;
  logic [7:0] r_wr_count;

  logic w_access;

  // The access edge is the WAIT edge on which the counter has reached zero.
  assign w_access = (r_state == c_st_wait) && (r_cnt == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_cnt       <= 4'd0;
      r_addr      <= 8'h00;
      r_data      <= 8'h00;
      r_wren      <= 1'b0;
      r_resp_wren <= 1'b0;
      r_resp_data <= 8'h00;
      r_rd_count  <= 8'h00;
      r_wr_count  <= 8'h00;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (req_valid) begin
            r_addr  <= req_address;
            r_data  <= req_data;
            r_wren  <= req_wren;
            r_cnt   <= c_lat_load;
            r_state <= c_st_wait;
          end
        end
        c_st_wait: begin
          if (r_cnt == 4'd0) begin
            r_resp_wren <= r_wren;
            if (r_wren) begin
              r_resp_data <= r_data;
              r_wr_count  <= r_wr_count + 8'd1;
            end else begin
              r_resp_data <= r_mem[r_addr];
              r_rd_count  <= r_rd_count + 8'd1;
            end
            r_state <= c_st_resp;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_st_resp: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Array write port; reset on the access edge suppresses the commit.
  always_ff @(posedge clock) begin
    if (!reset && w_access && r_wren) begin
      r_mem[r_addr] <= r_data;
    end
  end

  assign req_ready  = (r_state == c_st_idle);
  assign resp_valid = (r_state == c_st_resp);
  assign resp_wren  = r_resp_wren;
  assign resp_data  = r_resp_data;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;

endmodule
`default_nettype wire

// File: doc/mp_responder.md
# mp_responder

Main-memory responder serving the cache controller's fill and write-back traffic. It presents a 256 x 8 storage array behind a valid/ready request channel with a fixed, parameterised access latency. It returns a one-cycle response pulse for both reads and writes, replacing the ad-hoc pulsed-clock access used by the cache today. Each request is one 8-bit word: a read is a cache fill, a write is a dirty-line write-back.

## Interface
Parameters:
- LATENCY, default 2: cycles from request acceptance to the array access edge; legal range 1..15. Elaboration fails outside this range.
- INIT_PATTERN, default 1: when 1, power-up contents are mem[a] = a; when 0, power-up contents are all zero.

Ports (name, direction, width, meaning):
- clock, in, 1: single clock; everything is rising-edge.
- reset, in, 1: synchronous, active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: responder can accept a request.
- req_wren, in, 1: 1 = write, 0 = read.
- req_address, in, 8: word address.
- req_data, in, 8: write data; ignored for reads.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_wren, out, 1: echoes the accepted req_wren; valid while resp_valid = 1.
- resp_data, out, 8: read data, or the written data for a write.
- rd_count, out, 8: completed reads, wrapping modulo 256.
- wr_count, out, 8: completed writes, wrapping modulo 256.

## Operation
- States:
  - IDLE: req_ready = 1.
  - WAIT: req_ready = 0; 4-bit down-counter running.
  - RESP: req_ready = 0; resp_valid = 1.
- Accept: req_valid & req_ready sampled high on an edge.
  - Capture address, data and wren into internal registers.
  - Load counter = LATENCY-1.
  - Go to WAIT.
- WAIT:
  - Counter decrements each edge.
  - The edge on which the counter equals 0 is the access edge.
    - Write: mem[addr] <= data; wr_count + 1.
    - Read: resp_data <= mem[addr]; rd_count + 1.
    - Write: resp_data <= captured data.
  - Go to RESP on the access edge.
  - With LATENCY = 1 the counter is loaded with 0, so the first WAIT edge is the access edge.
- RESP: lasts exactly one cycle, then returns to IDLE.
- Initiator rules:
  - Hold req_valid and all request fields stable until accepted.
  - Requests presented while req_ready = 0 are not seen; they are neither queued nor dropped silently, because the initiator is still holding them.
- Ordering: strictly one outstanding request. A write is committed before its resp_valid, so a following read of the same address returns the new data.
- Array:
  - Plain registers; no byte enables.
  - The address uses the full 8 bits, so there is no out-of-range case.
- Reset:
  - IDLE; req_ready = 1.
  - resp_valid = 0, resp_wren = 0, resp_data = 0x00.
  - rd_count = 0, wr_count = 0.
  - Captured request registers cleared.
  - Array contents are NOT affected by reset.
- Reset mid-operation: the in-flight request is aborted with no response. If reset coincides with the access edge, reset wins: no array write and no count increment.

## Timing
- Accept on edge T0.
- Access on edge T0+LATENCY.
- resp_valid is high between edges T0+LATENCY and T0+LATENCY+1.
- req_ready rises after edge T0+LATENCY+1.
- The earliest next accept is edge T0+LATENCY+2, so sustained throughput is one request per LATENCY+2 cycles.
- resp_data and resp_wren hold their last values after resp_valid falls, until the next access edge.
- Counters wrap: 0xFF + 1 = 0x00, with no flag.
- req_valid asserted in the same cycle resp_valid is high is not accepted until IDLE.

## Test plan
- Reset, then read addr 0x05 with LATENCY = 2 and INIT_PATTERN = 1:
  - accepted on edge 1;
  - resp_valid high exactly one cycle after edge 3;
  - resp_data = 0x05, resp_wren = 0, rd_count = 1.
- Write 0x5A to 0x02, then read 0x02 back-to-back with req_valid held:
  - first resp: resp_wren = 1, resp_data = 0x5A;
  - second accept occurs exactly LATENCY+2 cycles after the first;
  - read returns 0x5A; wr_count = 1, rd_count = 1.
- LATENCY = 1 and LATENCY = 15 builds, read 0x03:
  - resp_valid appears 1 and 15 edges after accept respectively;
  - in each case req_ready is low from the accept edge until after RESP.
- Write 0x77 to 0x10 with reset asserted on the access edge:
  - no response;
  - wr_count stays 0;
  - a subsequent read of 0x10 returns 0x10.
- Issue 257 reads:
  - rd_count = 0x01 after wrap;
  - reset returns rd_count to 0x00 while a previously written location keeps its data.
- Hold req_valid with changing garbage fields while in WAIT/RESP:
  - no effect on the in-flight access;
  - the held request is accepted only in IDLE, with the fields present at that acceptance edge.
